// File: rtl/softmax_pkg.sv
// Shared fixed-point definitions for the softmax forward and backward blocks.
package softmax_pkg;

  localparam int FXP_IL   = 4;
  localparam int FXP_FL   = 16;
  localparam int FXP_W    = FXP_IL + FXP_FL;
  localparam int SAT_IN_W = 64;

  typedef logic signed [FXP_W-1:0] fxp_t;

  typedef struct packed {
    fxp_t value;
    logic ovf;
  } sat_t;

  typedef enum logic {LOAD, DRAIN} state_t;

  localparam logic signed [SAT_IN_W-1:0] FXP_MAX = (64'sd1 <<< (FXP_W - 1)) - 64'sd1;
  localparam logic signed [SAT_IN_W-1:0] FXP_MIN = -(64'sd1 <<< (FXP_W - 1));

  // Clamp a wide signed value into fxp_t; ovf flags that the clamp changed it.
  function automatic sat_t sat_w(input logic signed [SAT_IN_W-1:0] value);
    sat_t r;
    r.value = value[FXP_W-1:0];
    r.ovf   = 1'b0;
    if (value > FXP_MAX) begin
      r.value = FXP_MAX[FXP_W-1:0];
      r.ovf   = 1'b1;
    end else if (value < FXP_MIN) begin
      r.value = FXP_MIN[FXP_W-1:0];
      r.ovf   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fxp_mul_shift_sat.sv
// Signed multiply, arithmetic (floor) shift right by SHIFT, clamp to fxp_t.
// With b tied to 1 it doubles as a plain shift-and-saturate of a wide value.
module fxp_mul_shift_sat
  import softmax_pkg::*;
#(
  parameter int AW    = FXP_W,
  parameter int BW    = FXP_W + 1,
  parameter int SHIFT = FXP_FL
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output fxp_t                 result,
  output logic                 ovf
);

  // Full product width; must stay within the 64-bit saturation input.
  localparam int PW = AW + BW;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  sat_t                 clamp;

  assign a_ext   = PW'(a);
  assign b_ext   = PW'(b);
  assign prod    = a_ext * b_ext;
  assign shifted = prod >>> SHIFT;
  assign clamp   = sat_w(SAT_IN_W'(shifted));
  assign result  = clamp.value;
  assign ovf     = clamp.ovf;

endmodule

// File: rtl/softmax_backward.sv
// Streaming softmax gradient: buffers one row of (y, dy), forms dot = sum y*dy,
// then streams dx_i = y_i * (dy_i - dot), one element per cycle.
//
// state | meaning
// LOAD  | accepting y/dy pairs into the row buffers, accumulating y*dy
// DRAIN | emitting dx for each buffered element; input side stalled
module softmax_backward
  import softmax_pkg::*;
#(
  parameter int IL   = FXP_IL,
  parameter int FL   = FXP_FL,
  parameter int SIZE = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IL+FL-1:0]  in_y,
  input  logic signed [IL+FL-1:0]  in_dy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [IL+FL-1:0]  out_dx,
  output logic                     out_last,
  output logic                     sat
);

  localparam int W    = IL + FL;
  localparam int PW2  = 2 * W;
  localparam int DW   = W + 1;
  localparam int IW   = $clog2(SIZE);
  localparam int ACCW = 2 * W + $clog2(SIZE);
  localparam int LAST = SIZE - 1;

  logic signed [W-1:0]    y_buf  [SIZE];
  logic signed [W-1:0]    dy_buf [SIZE];
  state_t                 state, next_state;
  logic [IW-1:0]          idx;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_sum;
  logic signed [PW2-1:0]  prod_in;
  logic signed [DW-1:0]   diff;
  fxp_t                   dot, dot_sat, dx_val;
  logic                   dot_ovf, dx_ovf;
  logic                   at_last, in_hs, out_hs;

  assign prod_in = PW2'(in_y) * PW2'(in_dy);
  assign acc_sum = acc + ACCW'(prod_in);
  assign at_last = (idx == IW'(LAST));
  assign diff    = DW'(dy_buf[idx]) - DW'(dot);
  assign in_hs   = in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;

  // The last product is folded in here so dot is ready on the final load edge.
  fxp_mul_shift_sat #(.AW(ACCW), .BW(2), .SHIFT(FL)) u_dot_clamp (
    .a      (acc_sum),
    .b      (2'sb01),
    .result (dot_sat),
    .ovf    (dot_ovf)
  );

  fxp_mul_shift_sat #(.AW(W), .BW(DW), .SHIFT(FL)) u_dx (
    .a      (y_buf[idx]),
    .b      (diff),
    .result (dx_val),
    .ovf    (dx_ovf)
  );

  assign out_last = out_valid && at_last;
  assign out_dx   = out_valid ? dx_val : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && at_last) next_state = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && at_last) next_state = LOAD;
      end
    endcase
  end

  // Row buffers; contents are only read after a complete row, so no reset.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      y_buf[idx]  <= in_y;
      dy_buf[idx] <= in_dy;
    end
  end

  // Index, accumulator, dot register and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      acc <= '0;
      dot <= '0;
      sat <= 1'b0;
    end else begin
      if (in_hs || out_hs) idx <= at_last ? '0 : idx + IW'(1);
      if (in_hs) begin
        if (at_last) begin
          acc <= '0;
          dot <= dot_sat;
        end else begin
          acc <= acc_sum;
        end
      end
      sat <= sat | (in_hs && at_last && dot_ovf) | (out_hs && dx_ovf);
    end
  end

endmodule

// File: tb/tb_softmax_backward.sv
// Directed-vector and randomized-handshake bench for softmax_backward (SIZE=4).
module tb_softmax_backward;

  localparam int SIZE  = 4;
  localparam int NROWS = 100;
  localparam int NEL   = NROWS * SIZE;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_y;
  logic [19:0] in_dy;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_dx;
  logic        out_last;
  logic        sat;

  int checks = 0;
  int errors = 0;

  softmax_backward #(.IL(4), .FL(16), .SIZE(SIZE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_dy     (in_dy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dx    (out_dx),
    .out_last  (out_last),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][19:0] y;
    logic [3:0][19:0] dy;
    logic [3:0][19:0] dx;
    logic             s;
  } vec_t;

  vec_t vecs [5];

  logic [19:0] ry [NEL];
  logic [19:0] rdy [NEL];
  logic [19:0] ex_dx [NEL];
  logic        model_sat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0][19:0] p4(input logic [19:0] a0, input logic [19:0] a1,
                                          input logic [19:0] a2, input logic [19:0] a3);
    logic [3:0][19:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  function automatic longint clampv(input longint v);
    if (v > 64'sd524287) begin
      model_sat = 1'b1;
      return 64'sd524287;
    end
    if (v < -64'sd524288) begin
      model_sat = 1'b1;
      return -64'sd524288;
    end
    return v;
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " out_dx"},    {12'd0, out_dx},    32'd0);
    chk({tag, " out_last"},  {31'd0, out_last},  32'd0);
    chk({tag, " sat"},       {31'd0, sat},       32'd0);
  endtask

  task automatic load_row(input vec_t v, input string tag);
    for (int i = 0; i < SIZE; i++) begin
      in_valid = 1'b1;
      in_y     = v.y[i];
      in_dy    = v.dy[i];
      @(posedge clk); #1;
      if (i < SIZE - 1) chk($sformatf("%s early valid %0d", tag, i), {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_row(input vec_t v, input string tag);
    chk({tag, " latency out_valid"}, {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      chk($sformatf("%s dx%0d", tag, i),       {12'd0, out_dx},   {12'd0, v.dx[i]});
      chk($sformatf("%s last%0d", tag, i),     {31'd0, out_last}, (i == SIZE - 1) ? 32'd1 : 32'd0);
      chk($sformatf("%s in_ready%0d", tag, i), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk({tag, " sat"},        {31'd0, sat},       {31'd0, v.s});
    chk({tag, " in_ready"},   {31'd0, in_ready},  32'd1);
    chk({tag, " out_valid0"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    string names [5];
    int in_ptr, out_ptr, cyc;
    logic stalled_prev;
    logic [19:0] held_dx;
    logic held_last;

    // basic row
    vecs[0].y  = p4(20'h04000, 20'h04000, 20'h04000, 20'h04000);
    vecs[0].dy = p4(20'h10000, 20'h00000, 20'h00000, 20'h00000);
    vecs[0].dx = p4(20'h03000, 20'hFF000, 20'hFF000, 20'hFF000);
    vecs[0].s  = 1'b0;
    // uniform gradient: dx all zero
    vecs[1].y  = p4(20'h04000, 20'h04000, 20'h04000, 20'h04000);
    vecs[1].dy = p4(20'h08000, 20'h08000, 20'h08000, 20'h08000);
    vecs[1].dx = p4(20'h00000, 20'h00000, 20'h00000, 20'h00000);
    vecs[1].s  = 1'b0;
    // dot = 1 LSB; y = 1 LSB with diff = -1 LSB floors to -1 LSB
    vecs[2].y  = p4(20'h10000, 20'h00001, 20'h00001, 20'h00001);
    vecs[2].dy = p4(20'h00001, 20'h00000, 20'h00000, 20'h00000);
    vecs[2].dx = p4(20'h00000, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
    vecs[2].s  = 1'b0;
    // dot = -16 LSB, output products clamp both ways
    vecs[3].y  = p4(20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF);
    vecs[3].dy = p4(20'h7FFFF, 20'h80000, 20'h7FFFF, 20'h80000);
    vecs[3].dx = p4(20'h7FFFF, 20'h80000, 20'h7FFFF, 20'h80000);
    vecs[3].s  = 1'b1;
    // dot clamps to max, diff = 0
    vecs[4].y  = p4(20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF);
    vecs[4].dy = p4(20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF);
    vecs[4].dx = p4(20'h00000, 20'h00000, 20'h00000, 20'h00000);
    vecs[4].s  = 1'b1;
    names[0] = "basic"; names[1] = "uniform"; names[2] = "floor";
    names[3] = "outsat"; names[4] = "dotsat";

    in_valid = 1'b0; out_ready = 1'b0; in_y = '0; in_dy = '0; reset = 1'b1;
    @(posedge clk); #1;
    reset_checks("reset");
    reset = 1'b0;

    for (int k = 0; k < 5; k++) begin
      do_reset();
      load_row(vecs[k], names[k]);
      drain_row(vecs[k], names[k]);
    end

    // reset after two inputs of a saturating row
    do_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_y = vecs[3].y[i]; in_dy = vecs[3].dy[i];
      @(posedge clk); #1;
    end
    do_reset();
    reset_checks("midload");
    load_row(vecs[0], "after_midload");
    drain_row(vecs[0], "after_midload");

    // reset after one output; sat must be set by then and hold under stall
    do_reset();
    load_row(vecs[3], "middrain");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("middrain sat set", {31'd0, sat}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("middrain sat held", {31'd0, sat},    32'd1);
    chk("middrain dx held",  {12'd0, out_dx}, 32'h80000);
    do_reset();
    reset_checks("middrain");
    load_row(vecs[0], "after_middrain");
    drain_row(vecs[0], "after_middrain");

    // random rows with 30% duty on both handshakes against a longint model
    model_sat = 1'b0;
    for (int r = 0; r < NROWS; r++) begin
      longint acc, dot, t;
      bit full;
      full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < SIZE; i++) begin
        int k;
        k = r * SIZE + i;
        ry[k]  = full ? 20'($urandom) : 20'($signed(17'($urandom)));
        rdy[k] = full ? 20'($urandom) : 20'($signed(18'($urandom)));
      end
      acc = 0;
      for (int i = 0; i < SIZE; i++)
        acc += longint'($signed(ry[r*SIZE+i])) * longint'($signed(rdy[r*SIZE+i]));
      dot = clampv(acc >>> 16);
      for (int i = 0; i < SIZE; i++) begin
        longint diff;
        diff = longint'($signed(rdy[r*SIZE+i])) - dot;
        t = clampv((longint'($signed(ry[r*SIZE+i])) * diff) >>> 16);
        ex_dx[r*SIZE+i] = t[19:0];
      end
    end

    do_reset();
    in_ptr = 0; out_ptr = 0; cyc = 0;
    stalled_prev = 1'b0; held_dx = '0; held_last = 1'b0;
    while (out_ptr < NEL && cyc < 20000) begin
      in_valid = (in_ptr < NEL) && ($urandom_range(0, 99) < 30);
      if (in_ptr < NEL) begin
        in_y  = ry[in_ptr];
        in_dy = rdy[in_ptr];
      end
      out_ready = ($urandom_range(0, 99) < 30);
      if (stalled_prev) begin
        chk("stall valid", {31'd0, out_valid}, 32'd1);
        chk("stall dx",    {12'd0, out_dx},    {12'd0, held_dx});
        chk("stall last",  {31'd0, out_last},  {31'd0, held_last});
      end
      if (out_valid) chk("drain in_ready", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        chk($sformatf("rand dx%0d", out_ptr), {12'd0, out_dx}, {12'd0, ex_dx[out_ptr]});
        chk($sformatf("rand last%0d", out_ptr), {31'd0, out_last},
            (out_ptr % SIZE == SIZE - 1) ? 32'd1 : 32'd0);
        out_ptr++;
      end
      if (in_valid && in_ready) in_ptr++;
      stalled_prev = out_valid && !out_ready;
      held_dx      = out_dx;
      held_last    = out_last;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rand output count", out_ptr, NEL);
    chk("rand sat", {31'd0, sat}, {31'd0, model_sat});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/softmax_backward.md
# softmax_backward

Streaming fixed-point softmax gradient unit for the transformer training path: the backward counterpart of the forward softmax block. For each attention row of SIZE elements it accepts the forward output y and upstream gradient dy, and buffers the row. It accumulates dot = Σ y·dy, then emits dx_i = y_i·(dy_i − dot) one element per cycle. It sits between the gradient buffer and the backward matmul engine and uses valid/ready handshakes on both sides.

## Interface
- IL, 4: integer bits of the signed fixed-point format
- FL, 16: fractional bits; W = IL+FL total width
- SIZE, 16: elements per row; must be ≥ 2
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- in_valid  in  1  y/dy pair offered
- in_ready  out  1  block accepts a pair this cycle
- in_y  in  W  signed forward softmax output y_i
- in_dy  in  W  signed upstream gradient dy_i
- out_valid  out  1  dx element available
- out_ready  in  1  consumer accepts dx
- out_dx  out  W  signed dx_i
- out_last  out  1  high with the final element (index SIZE−1) of a row
- sat  out  1  sticky; set when any saturation occurs; cleared only by reset

## Operation
- FSM has two states. LOAD is the reset state; DRAIN follows.
- LOAD behaviour:
  - in_ready = 1.
  - On each handshake, store y and dy at index idx and add the full-precision product y·dy (2W bits) to acc.
  - The accumulator is 2W+$clog2(SIZE) bits, so it never overflows.
  - idx increments on each handshake.
  - On the handshake with idx = SIZE−1:
    - dot ← sat_W((acc + y·dy) >>> FL), an arithmetic shift (floor).
    - acc ← 0, idx ← 0, and the FSM moves to DRAIN.
- DRAIN behaviour:
  - in_ready = 0, out_valid = 1.
  - Datapath: diff = dy[idx] − dot in W+1 bits, with no saturation. Then out_dx = sat_W((y[idx]·diff) >>> FL), an arithmetic shift (floor).
  - out_last = (idx == SIZE−1).
  - On each out handshake, idx increments. On the handshake with out_last, idx ← 0 and the FSM moves to LOAD.
- sat_W clamps to [−2^(W−1), 2^(W−1)−1]. Whenever a clamp actually changes a value, sat is set on the same clock edge as the update it affects: the dot register for the dot clamp, the out handshake for the output clamp.
- Rows are processed strictly one at a time; load and drain do not overlap.
- While out_ready = 0, out_dx, out_last and out_valid hold their values.
- Reset mid-row (either state):
  - The FSM returns to LOAD with idx, acc and dot cleared and sat cleared.
  - The partial row is discarded, and no stale dx is emitted afterwards.
- in_valid is ignored in DRAIN. out_ready is ignored in LOAD.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_dx = 0, out_last = 0, sat = 0.
- Load: a row takes SIZE cycles at full rate. in_valid gaps stall the load without losing state.
- Latency: the last input handshake happens at edge N; out_valid = 1 in the cycle after edge N, with dx_0 valid in that cycle.
- Drain: SIZE cycles at full rate. in_ready rises in the cycle after the out_last handshake.
- Throughput: 2·SIZE cycles per row with no stalls.
- out_dx is a combinational function of the buffer entry, the dot register and idx. All state is registered. The longest path is one W×(W+1) multiply plus the saturation logic.

## Structure
- Package softmax_pkg holds:
  - IL, FL and W defaults
  - fxp_t, a signed [W-1:0] typedef
  - function sat_w(value) returning fxp_t plus an overflow bit
  - the FSM enum state_t {LOAD, DRAIN}
- The forward softmax block shares this package.
- Sub-module fxp_mul_shift_sat holds the signed multiply, the arithmetic shift by FL and the saturation with overflow flag. It is instantiated twice: once for the per-element dx, and once for the final dot clamp applied to a wide shifted value.
- Buffers: two SIZE×W register arrays for y and dy, with no RAM macro.

## Test plan
- Basic row: SIZE=4, y = 0x04000 ×4 (0.25 each), dy = [0x10000, 0, 0, 0] → dot = 0x04000; dx = [0x03000, −0x01000, −0x01000, −0x01000]; out_last on the 4th output; sat = 0.
- Uniform gradient: y = 0x04000 ×4, dy = 0x08000 ×4 → dot = 0x08000; all dx = 0; latency of exactly 1 cycle from the last input to out_valid.
- Backpressure and gaps: random in_valid and out_ready duty of 30%, 100 rows → outputs match a golden model bit-exactly; out_dx and out_last stay stable while stalled; in_ready = 0 throughout DRAIN.
- Saturation: y = 0x7FFFF, dy = [0x7FFFF, 0x80000, …] chosen so that y·diff exceeds the range → out_dx = 0x7FFFF or 0x80000; sat goes high and stays high until reset.
- Reset mid-operation: assert reset after 2 inputs, and again after 1 output → in_ready = 1, out_valid = 0, sat = 0 the next cycle; the following full row produces correct results with no stale data.
- Negative floor rounding: y = 0x00001, diff = −1 LSB → product >>> 16 gives out_dx = 0xFFFFF (−1 LSB, rounding toward −∞).
